// File: rtl/w5300_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// w5300_bus_ctrl_pkg
// Shared constants for the W5300 physical-bus master: the direction bit
// encoding carried in addr[10] and the default bus/reset timing in clock
// cycles (50 MHz system clock assumed for the reset timing defaults).
// Also provides a small integer max helper for sizing counters.
// -----------------------------------------------------------------------------
package w5300_bus_ctrl_pkg;

    // Direction bit carried in addr[10] of an upstream request
    localparam logic BUS_OP_WR = 1'b1;
    localparam logic BUS_OP_RD = 1'b0;

    // Default bus timing, in clock cycles
    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_STROBE_CYC  = 4;
    localparam int DEF_HOLD_CYC    = 1;
    localparam int DEF_RECOVER_CYC = 2;

    // Default chip reset timing: 5 us low, 10 ms PLL lock wait at 50 MHz
    localparam int DEF_RST_LOW_CYC  = 250;
    localparam int DEF_RST_WAIT_CYC = 500000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/w5300_bus_ctrl_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset; both flops load RESET_VAL
//   d      in  asynchronous input
//   q      out synchronised output (2-3 cycles latency from a d edge)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/w5300_bus_ctrl.sv
// -----------------------------------------------------------------------------
// w5300_bus_ctrl
// Physical-bus master for the Wiznet W5300 in 16-bit direct-address mode.
// Sequences the chip hardware reset after power-up, then executes the single
// read/write request presented upstream on addr/wr_data, pulsing op_state
// once per completed transaction. Also synchronises the chip interrupt.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   enable               request transactions continuously while high
//   addr[10:0]           bit 10 = write(1)/read(0), bits 9:0 = chip address
//   wr_data[15:0]        write data
//   op_state             one-cycle pulse in the first RECOVER cycle
//   rd_data[15:0]        data from the last completed read
//   ready                high once the chip reset sequence has finished
//   irq                  synchronised, active-high bus_int_n
//   w5300_rst_n          chip hardware reset
//   bus_cs_n/wr_n/rd_n   chip strobes
//   bus_addr[9:0]        chip address
//   bus_data_o/oe/i      pad data out, output enable, pad data in
//   bus_int_n            chip interrupt (asynchronous)
// -----------------------------------------------------------------------------
module w5300_bus_ctrl
    import w5300_bus_ctrl_pkg::*;
#(
    parameter int SETUP_CYC    = DEF_SETUP_CYC,
    parameter int STROBE_CYC   = DEF_STROBE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int RECOVER_CYC  = DEF_RECOVER_CYC,
    parameter int RST_LOW_CYC  = DEF_RST_LOW_CYC,
    parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] addr,
    input  logic [15:0] wr_data,
    output logic        op_state,
    output logic [15:0] rd_data,
    output logic        ready,
    output logic        irq,
    output logic        w5300_rst_n,
    output logic        bus_cs_n,
    output logic        bus_wr_n,
    output logic        bus_rd_n,
    output logic [9:0]  bus_addr,
    output logic [15:0] bus_data_o,
    output logic        bus_data_oe,
    input  logic [15:0] bus_data_i,
    input  logic        bus_int_n
);

    // A zero-length phase would break the single down-counter scheme
    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || RECOVER_CYC < 1 ||
        RST_LOW_CYC < 1 || RST_WAIT_CYC < 1) begin : g_param_check
        $error("w5300_bus_ctrl: every timing parameter must be >= 1");
    end

    localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, STROBE_CYC),
                                             max_int(HOLD_CYC, RECOVER_CYC)),
                                     max_int(RST_LOW_CYC, RST_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_done;
    logic               is_wr;
    logic               int_sync;

    logic               is_wr_d;
    logic               op_state_d;
    logic [15:0]        rd_data_d;
    logic               ready_d;
    logic               w5300_rst_n_d;
    logic               bus_cs_n_d;
    logic               bus_wr_n_d;
    logic               bus_rd_n_d;
    logic [9:0]         bus_addr_d;
    logic [15:0]        bus_data_o_d;
    logic               bus_data_oe_d;

    // The counter holds (length - 1) on entry, so a state lasts its full
    // parameter length and leaves on the cycle the counter reads zero.
    function automatic logic [CNT_W-1:0] cnt_load(input state_t s);
        case (s)
            ST_RST_LOW:  return CNT_W'(RST_LOW_CYC - 1);
            ST_RST_WAIT: return CNT_W'(RST_WAIT_CYC - 1);
            ST_SETUP:    return CNT_W'(SETUP_CYC - 1);
            ST_STROBE:   return CNT_W'(STROBE_CYC - 1);
            ST_HOLD:     return CNT_W'(HOLD_CYC - 1);
            ST_RECOVER:  return CNT_W'(RECOVER_CYC - 1);
            default:     return '0;
        endcase
    endfunction

    assign cnt_done = (cnt == '0);

    // State register and the shared phase counter, reloaded on every entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RST_LOW;
            cnt   <= cnt_load(ST_RST_LOW);
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= cnt_load(state_nxt);
            end else if (!cnt_done) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Next-state logic; enable is only looked at once the chip is out of reset
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST_LOW:  if (cnt_done) state_nxt = ST_RST_WAIT;
            ST_RST_WAIT: if (cnt_done) state_nxt = ST_IDLE;
            ST_IDLE:     if (enable)   state_nxt = ST_SETUP;
            ST_SETUP:    if (cnt_done) state_nxt = ST_STROBE;
            ST_STROBE:   if (cnt_done) state_nxt = ST_HOLD;
            ST_HOLD:     if (cnt_done) state_nxt = ST_RECOVER;
            ST_RECOVER:  if (cnt_done) state_nxt = enable ? ST_SETUP : ST_IDLE;
            default:     state_nxt = ST_RST_LOW;
        endcase
    end

    // Output logic is decoded from the next state and registered below, so
    // every pin changes on the same edge as the state it belongs to. The
    // request is latched on the edge that enters SETUP from IDLE/RECOVER.
    always_comb begin
        logic latch;
        logic in_xfer;

        latch   = (state_nxt == ST_SETUP) &&
                  ((state == ST_IDLE) || (state == ST_RECOVER));
        in_xfer = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                  (state_nxt == ST_HOLD);

        is_wr_d       = latch ? (addr[10] == BUS_OP_WR) : is_wr;
        bus_addr_d    = latch ? addr[9:0] : bus_addr;
        bus_data_o_d  = (latch && (addr[10] == BUS_OP_WR)) ? wr_data : bus_data_o;

        bus_cs_n_d    = !in_xfer;
        bus_wr_n_d    = !((state_nxt == ST_STROBE) && is_wr_d);
        bus_rd_n_d    = !((state_nxt == ST_STROBE) && !is_wr_d);
        bus_data_oe_d = in_xfer && is_wr_d;

        op_state_d    = (state == ST_HOLD) && (state_nxt == ST_RECOVER);
        rd_data_d     = ((state == ST_STROBE) && (state_nxt == ST_HOLD) && !is_wr)
                        ? bus_data_i : rd_data;

        w5300_rst_n_d = (state_nxt != ST_RST_LOW);
        ready_d       = (state_nxt != ST_RST_LOW) && (state_nxt != ST_RST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_wr       <= 1'b0;
            op_state    <= 1'b0;
            rd_data     <= '0;
            ready       <= 1'b0;
            w5300_rst_n <= 1'b0;
            bus_cs_n    <= 1'b1;
            bus_wr_n    <= 1'b1;
            bus_rd_n    <= 1'b1;
            bus_addr    <= '0;
            bus_data_o  <= '0;
            bus_data_oe <= 1'b0;
        end else begin
            is_wr       <= is_wr_d;
            op_state    <= op_state_d;
            rd_data     <= rd_data_d;
            ready       <= ready_d;
            w5300_rst_n <= w5300_rst_n_d;
            bus_cs_n    <= bus_cs_n_d;
            bus_wr_n    <= bus_wr_n_d;
            bus_rd_n    <= bus_rd_n_d;
            bus_addr    <= bus_addr_d;
            bus_data_o  <= bus_data_o_d;
            bus_data_oe <= bus_data_oe_d;
        end
    end

    // Flops reset to the idle (high) level so irq comes out of reset low
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus_int_n),
        .q     (int_sync)
    );

    assign irq = ~int_sync;

endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_w5300_bus_ctrl
// Scoreboard bench for w5300_bus_ctrl. Stimulus pushes the expected
// transaction into a queue; a bus monitor tracks strobe activity and, on each
// op_state pulse, pops the queue and compares what happened on the pins.
// -----------------------------------------------------------------------------
module tb_w5300_bus_ctrl;

    localparam int RST_LOW_CYC  = 5;
    localparam int RST_WAIT_CYC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [10:0] addr;
    logic [15:0] wr_data;
    logic        op_state;
    logic [15:0] rd_data;
    logic        ready;
    logic        irq;
    logic        w5300_rst_n;
    logic        bus_cs_n;
    logic        bus_wr_n;
    logic        bus_rd_n;
    logic [9:0]  bus_addr;
    logic [15:0] bus_data_o;
    logic        bus_data_oe;
    logic [15:0] bus_data_i;
    logic        bus_int_n;

    w5300_bus_ctrl #(
        .RST_LOW_CYC  (RST_LOW_CYC),
        .RST_WAIT_CYC (RST_WAIT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .addr        (addr),
        .wr_data     (wr_data),
        .op_state    (op_state),
        .rd_data     (rd_data),
        .ready       (ready),
        .irq         (irq),
        .w5300_rst_n (w5300_rst_n),
        .bus_cs_n    (bus_cs_n),
        .bus_wr_n    (bus_wr_n),
        .bus_rd_n    (bus_rd_n),
        .bus_addr    (bus_addr),
        .bus_data_o  (bus_data_o),
        .bus_data_oe (bus_data_oe),
        .bus_data_i  (bus_data_i),
        .bus_int_n   (bus_int_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [9:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   pulse_cnt = 0;
    int   expected_pulses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Bus monitor: counts strobe cycles per transaction and scores on op_state
    int          cs_cnt = 0, wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, fall_cyc = 0;
    logic        prev_cs = 1'b1;
    logic [9:0]  cap_addr = '0;
    logic [15:0] cap_data = '0;
    logic [15:0] last_rd = '0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            cs_cnt = 0; wr_cnt = 0; rd_cnt = 0; oe_cnt = 0;
            prev_cs = 1'b1;
            last_rd = '0;
        end else begin
            if (op_state) begin
                pulse_cnt++;
                checkOutput("op_state while ready", 32'(ready), 32'd1);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected op_state", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("latch to op_state cycles", 32'(cyc - fall_cyc), 32'd6);
                    checkOutput("cs_n low cycles", 32'(cs_cnt), 32'd6);
                    checkOutput("bus_addr", 32'(cap_addr), 32'(mon_e.a));
                    if (mon_e.wr) begin
                        checkOutput("wr_n low cycles", 32'(wr_cnt), 32'd4);
                        checkOutput("rd_n low cycles (write)", 32'(rd_cnt), 32'd0);
                        checkOutput("data_oe cycles (write)", 32'(oe_cnt), 32'd6);
                        checkOutput("bus_data_o", 32'(cap_data), 32'(mon_e.d));
                        checkOutput("rd_data held over write", 32'(rd_data), 32'(last_rd));
                    end else begin
                        checkOutput("rd_n low cycles", 32'(rd_cnt), 32'd4);
                        checkOutput("wr_n low cycles (read)", 32'(wr_cnt), 32'd0);
                        checkOutput("data_oe cycles (read)", 32'(oe_cnt), 32'd0);
                        checkOutput("rd_data", 32'(rd_data), 32'(mon_e.d));
                        last_rd = mon_e.d;
                    end
                end
                cs_cnt = 0; wr_cnt = 0; rd_cnt = 0; oe_cnt = 0;
            end
            if (!bus_cs_n && prev_cs) fall_cyc = cyc;
            if (!bus_cs_n) cs_cnt++;
            if (!bus_wr_n) begin
                wr_cnt++;
                cap_addr = bus_addr;
                cap_data = bus_data_o;
            end
            if (!bus_rd_n) begin
                rd_cnt++;
                cap_addr = bus_addr;
            end
            if (bus_data_oe) oe_cnt++;
            prev_cs = bus_cs_n;
        end
    end

    // Bounded wait on a DUT event, sampled on the falling edge
    // sel: 0 = cs_n low, 1 = op_state, 2 = rd_n low, 3 = wr_n low
    task automatic waitUntil(input string name, input int sel, output int at_cyc);
        int n   = 0;
        bit hit = 0;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = !bus_cs_n;
                1:       hit = op_state;
                2:       hit = !bus_rd_n;
                default: hit = !bus_wr_n;
            endcase
        end
        at_cyc = cyc;
        if (!hit) checkOutput({name, " timeout"}, 32'd0, 32'd1);
    endtask

    // mode 0: keep enable high, 1: drop enable after the latch,
    // 2: drop enable during the strobe
    task automatic applyStimulus(input logic wr, input logic [9:0] a,
                                 input logic [15:0] d, input int mode,
                                 output int op_cyc);
        exp_t e;
        int   t;
        e.wr = wr; e.a = a; e.d = d;
        addr    = {wr, a};
        wr_data = wr ? d : 16'hDEAD;
        if (!wr) bus_data_i = d;
        exp_q.push_back(e);
        expected_pulses++;
        enable = 1'b1;
        if (mode == 2) waitUntil("strobe", wr ? 3 : 2, t);
        else           waitUntil("latch", 0, t);
        // Upstream moves on after the latch; the running transaction must not care
        addr    = {wr, ~a};
        wr_data = ~d;
        if (mode != 0) enable = 1'b0;
        waitUntil("op_state", 1, op_cyc);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " bus_cs_n"},    32'(bus_cs_n),    32'd1);
        checkOutput({tag, " bus_wr_n"},    32'(bus_wr_n),    32'd1);
        checkOutput({tag, " bus_rd_n"},    32'(bus_rd_n),    32'd1);
        checkOutput({tag, " bus_addr"},    32'(bus_addr),    32'd0);
        checkOutput({tag, " bus_data_o"},  32'(bus_data_o),  32'd0);
        checkOutput({tag, " bus_data_oe"}, 32'(bus_data_oe), 32'd0);
        checkOutput({tag, " w5300_rst_n"}, 32'(w5300_rst_n), 32'd0);
        checkOutput({tag, " op_state"},    32'(op_state),    32'd0);
        checkOutput({tag, " rd_data"},     32'(rd_data),     32'd0);
        checkOutput({tag, " ready"},       32'(ready),       32'd0);
        checkOutput({tag, " irq"},         32'(irq),         32'd0);
    endtask

    // Releases rst_n and times the chip reset and ready against edge count
    task automatic powerUp(input string tag);
        int first_rst = -1;
        int first_rdy = -1;
        bit strobe    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (w5300_rst_n && first_rst < 0) first_rst = k;
            if (ready && first_rdy < 0) first_rdy = k;
            if (!ready && (!bus_cs_n || !bus_wr_n || !bus_rd_n)) strobe = 1;
        end
        checkOutput({tag, " w5300_rst_n rise edge"}, 32'(first_rst), 32'd5);
        checkOutput({tag, " ready rise edge"},       32'(first_rdy), 32'd15);
        checkOutput({tag, " strobes before ready"},  32'(strobe),    32'd0);
    endtask

    initial begin
        int op_cyc, prev_cyc;
        bit idle_ok;

        rst_n      = 1'b0;
        enable     = 1'b0;
        addr       = '0;
        wr_data    = '0;
        bus_data_i = '0;
        bus_int_n  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");

        // Request pending across power-up: must wait for ready
        begin
            exp_t e;
            e.wr = 1'b1; e.a = 10'h0AA; e.d = 16'hC0DE;
            addr    = {1'b1, 10'h0AA};
            wr_data = 16'hC0DE;
            exp_q.push_back(e);
            expected_pulses++;
            enable  = 1'b1;
        end
        powerUp("power-up");
        enable = 1'b0;
        waitUntil("first op_state", 1, op_cyc);
        repeat (3) @(negedge clk);

        $display("[TB] single write / read");
        applyStimulus(1'b1, 10'h000, 16'h0101, 1, op_cyc);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 10'h208, 16'h0013, 1, op_cyc);
        repeat (3) @(negedge clk);

        $display("[TB] back-to-back writes");
        for (int i = 0; i < 13; i++) begin
            prev_cyc = op_cyc;
            applyStimulus(1'b1, 10'(10'h010 + i * 3), 16'(16'h1000 + i * 16'h0111),
                          (i == 12) ? 1 : 0, op_cyc);
            if (i > 0) checkOutput("back-to-back op_state spacing",
                                   32'(op_cyc - prev_cyc), 32'd8);
        end
        repeat (3) @(negedge clk);

        $display("[TB] enable dropped in strobe");
        applyStimulus(1'b0, 10'h3FF, 16'hBEEF, 2, op_cyc);
        idle_ok = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!bus_cs_n) idle_ok = 0;
        end
        checkOutput("idle after enable drop", 32'(idle_ok), 32'd1);

        $display("[TB] interrupt synchroniser");
        @(negedge clk);
        bus_int_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("irq after 1 edge", 32'(irq), 32'd0);
        @(posedge clk); #1;
        checkOutput("irq after 2 edges", 32'(irq), 32'd1);
        @(negedge clk);
        bus_int_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("irq released", 32'(irq), 32'd0);

        $display("[TB] reset mid-read");
        @(negedge clk);
        bus_data_i = 16'h1234;
        addr       = {1'b0, 10'h055};
        enable     = 1'b1;
        waitUntil("mid-read strobe", 2, op_cyc);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkResetValues("mid-read reset");
        exp_q.delete();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        powerUp("re-power");
        repeat (2) @(negedge clk);

        applyStimulus(1'b0, 10'h123, 16'h5A5A, 1, op_cyc);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 10'h3C0, 16'h7777, 1, op_cyc);
        repeat (4) @(negedge clk);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        checkOutput("op_state pulse count", 32'(pulse_cnt), 32'(expected_pulses));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/w5300_bus_ctrl.md
# w5300_bus_ctrl

Physical-bus master for the Wiznet W5300 in 16-bit direct-address mode. Sits directly downstream of the register-configuration stages: it executes the single read/write request they present on `addr`/`wr_data`, pulses `op_state` when that transaction completes, and returns `rd_data`. It also sequences the chip's hardware reset at power-up and synchronises the chip's interrupt line.

## Interface
Parameters:
- SETUP_CYC, 1: cycles with CS_n low and address valid before the strobe.
- STROBE_CYC, 4: cycles with WR_n/RD_n low.
- HOLD_CYC, 1: cycles after the strobe with CS_n low and address/data held.
- RECOVER_CYC, 2: cycles with CS_n high between transactions.
- RST_LOW_CYC, 250: cycles `w5300_rst_n` is held low (5 us at 50 MHz).
- RST_WAIT_CYC, 500000: cycles after reset release before the first transaction (10 ms PLL lock).

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- enable  in  1  request transactions continuously while high.
- addr  in  11  bit 10 = WR (1) / RD (0); bits 9:0 = W5300 address.
- wr_data  in  16  write data.
- op_state  out  1  one-cycle pulse when a transaction completes.
- rd_data  out  16  data from the last completed read; held until the next read.
- ready  out  1  high once the chip reset sequence has finished.
- irq  out  1  synchronised, active-high version of `bus_int_n`.
- w5300_rst_n  out  1  chip hardware reset.
- bus_cs_n, bus_wr_n, bus_rd_n  out  1 each  chip strobes.
- bus_addr  out  10  chip address.
- bus_data_o  out  16  write data to the pad.
- bus_data_oe  out  1  pad output enable; the top level builds the tristate.
- bus_data_i  in  16  read data from the pad.
- bus_int_n  in  1  chip interrupt, asynchronous.

## Operation
- States: RST_LOW → RST_WAIT → IDLE → SETUP → STROBE → HOLD → RECOVER.
  - RECOVER → SETUP when `enable` is high; otherwise → IDLE.
  - IDLE → SETUP when `enable` is high.
- RST_LOW: `w5300_rst_n` = 0 for RST_LOW_CYC cycles.
- RST_WAIT: `w5300_rst_n` = 1 for RST_WAIT_CYC cycles, then `ready` = 1 permanently until reset.
- `enable` is ignored before `ready` is high; `op_state` never pulses before `ready`.
- Entering SETUP latches `addr` and `wr_data`. Upstream changes after the latch have no effect on the running transaction.
- Write transaction (`addr[10]` = 1):
  - `bus_data_oe` = 1 and `bus_data_o` = latched `wr_data` from SETUP through HOLD.
  - `bus_wr_n` = 0 during STROBE only.
- Read transaction (`addr[10]` = 0):
  - `bus_data_oe` = 0 throughout.
  - `bus_rd_n` = 0 during STROBE.
  - `rd_data` is registered from `bus_data_i` on the edge leaving the last STROBE cycle.
  - Writes never modify `rd_data`.
- `bus_cs_n` = 0 from SETUP through HOLD; 1 otherwise. `bus_addr` = latched `addr[9:0]`, held through RECOVER.
- `op_state` = 1 for exactly the first RECOVER cycle. Upstream advances its operation counter on that edge, and the next SETUP latches the new request.
- `enable` falling mid-transaction does not abort it: the transaction completes, `op_state` still pulses, and the FSM then goes to IDLE.
- `irq` = NOT of `bus_int_n` after a two-flop synchroniser.
- Synchronous reset in any state:
  - returns the FSM to RST_LOW, re-asserting the chip reset;
  - clears `ready` and any pending transaction.

## Timing
- Reset values: `bus_cs_n`, `bus_wr_n`, `bus_rd_n` = 1; `bus_addr` = 0; `bus_data_o` = 0; `bus_data_oe` = 0; `w5300_rst_n` = 0; `op_state` = 0; `rd_data` = 0; `ready` = 0; `irq` = 0 (synchroniser flops reset to 1).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Transaction period, back-to-back = SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOVER_CYC = 8 cycles with defaults.
- `op_state` fires SETUP_CYC + STROBE_CYC + HOLD_CYC cycles after the latch edge.
- `rd_data` is valid in the cycle `op_state` is high, and at least HOLD_CYC cycles earlier.
- `ready` rises RST_LOW_CYC + RST_WAIT_CYC cycles after `rst_n` deasserts.
- A single down-counter, width $clog2(max parameter + 1), serves all timed states and reloads on every state entry.
- Every parameter must be ≥ 1; a compile-time assertion fails elaboration otherwise.
- `irq` latency: 2–3 cycles from a `bus_int_n` edge.

## Structure
- The `WR`/`RD` bit constants and the default timing-parameter values live in the shared `W5300` package.
- The FSM state enum is local to the module.
- One sub-module: `sync_2ff` (generic two-flop synchroniser), used for `bus_int_n`.

## Test plan
- Power-up: release `rst_n`, with parameters overridden to RST_LOW_CYC = 5 and RST_WAIT_CYC = 10 → `w5300_rst_n` is low for 5 cycles; `ready` rises at cycle 15; no strobe activity before then.
- Single write: `addr` = {1, 10'h000}, `wr_data` = 16'h0101 → CS low for 6 cycles, WR_n low for 4, `bus_data_oe` high for 6, `op_state` one pulse 6 cycles after the latch; `rd_data` unchanged.
- Single read: `addr` = {0, 10'h208}, `bus_data_i` = 16'h0013 → RD_n low for 4 cycles; `rd_data` = 16'h0013 at `op_state`; `bus_data_oe` stays 0.
- Back-to-back: `enable` held high, 13 distinct writes with upstream advancing on `op_state` → 13 pulses exactly 8 cycles apart, and each transaction carries the address/data presented before its latch edge.
- `enable` dropped in STROBE → the transaction completes, `op_state` pulses once, then IDLE with CS_n high.
- `rst_n` asserted mid-read → all outputs return to reset values next cycle; `w5300_rst_n` = 0; the full reset sequence repeats.
